// File: rtl/zbt_sram_arbiter.sv
// Multi-client controller for one pipelined ZBT SRAM bank: round-robin or fixed-priority
// arbitration, one access per cycle, in-order read responses at a fixed latency.
module zbt_sram_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [ADDR_W-1:0]          sram_address_out,
    output logic [DATA_W-1:0]          sram_data_O,
    input  logic [DATA_W-1:0]          sram_data_I,
    output logic                       sram_data_T,
    output logic [DATA_W/8-1:0]        sram_we_bytes_out,
    output logic                       sram_we_out,
    output logic                       sram_ce_out,
    output logic                       sram_oe_out,
    output logic                       sram_cen_out,
    output logic                       sram_adv_ld_out,
    output logic                       busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   cand;
    logic              gnt_any;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              sel_write;
    logic              wr_next;

    logic              pipe_vld   [READ_LAT+1];
    logic              pipe_wr    [READ_LAT+1];
    logic [CH_W-1:0]   pipe_ch    [READ_LAT+1];
    logic [DATA_W-1:0] pipe_wdata [READ_LAT+1];

    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NUM_CH;
        return CH_W'(s);
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (ARB_MODE == 0) ? rr_index(rr_ptr, i + 1) : CH_W'(i);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    // sram_cen_out doubles as the "out of reset for one edge" flag that gates grants
    assign xfer = gnt_any & ~sram_cen_out;

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[gnt_ch] = 1'b1;
    end

    assign sel_addr  = req_addr[32'(gnt_ch) * ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[32'(gnt_ch) * DATA_W +: DATA_W];
    assign sel_be    = req_be[32'(gnt_ch) * BE_W +: BE_W];
    assign sel_write = req_write[gnt_ch];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rr_ptr <= CH_W'(NUM_CH - 1);
        else if (xfer)
            rr_ptr <= gnt_ch;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i <= READ_LAT; i++) begin
                pipe_vld[i]   <= 1'b0;
                pipe_wr[i]    <= 1'b0;
                pipe_ch[i]    <= '0;
                pipe_wdata[i] <= '0;
            end
        end else begin
            pipe_vld[0]   <= xfer;
            pipe_wr[0]    <= sel_write;
            pipe_ch[0]    <= gnt_ch;
            pipe_wdata[0] <= sel_wdata;
            for (int unsigned i = 1; i <= READ_LAT; i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_wr[i]    <= pipe_wr[i-1];
                pipe_ch[i]    <= pipe_ch[i-1];
                pipe_wdata[i] <= pipe_wdata[i-1];
            end
        end
    end

    // Stage READ_LAT-1 becomes the data cycle on the next edge, so the bus pins are loaded from it.
    assign wr_next = pipe_vld[READ_LAT-1] & pipe_wr[READ_LAT-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sram_address_out  <= '0;
            sram_we_bytes_out <= '1;
            sram_we_out       <= 1'b1;
            sram_ce_out       <= 1'b1;
            sram_cen_out      <= 1'b1;
            sram_data_O       <= '0;
            sram_data_T       <= 1'b1;
            sram_oe_out       <= 1'b1;
        end else begin
            sram_cen_out      <= 1'b0;
            sram_ce_out       <= ~xfer;
            sram_we_out       <= ~(xfer & sel_write);
            sram_we_bytes_out <= (xfer && sel_write) ? ~sel_be : '1;
            if (xfer)
                sram_address_out <= sel_addr;
            sram_data_T <= ~wr_next;
            sram_oe_out <= wr_next;
            if (wr_next)
                sram_data_O <= pipe_wdata[READ_LAT-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (pipe_vld[READ_LAT] && !pipe_wr[READ_LAT]) begin
                resp_valid[pipe_ch[READ_LAT]] <= 1'b1;
                resp_data                     <= sram_data_I;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i <= READ_LAT; i++)
            busy = busy | pipe_vld[i];
    end

    assign sram_adv_ld_out = 1'b0;

endmodule

// File: tb/tb_zbt_sram_arbiter.sv
// Scoreboard bench for zbt_sram_arbiter: pin-level ZBT model, issue-order reference memory,
// round-robin and fixed-priority grant sequences, mid-flight reset.
module tb_zbt_sram_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int BW  = 4;

    typedef struct packed {
        int          due;
        logic [17:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        int          due;
        int          ch;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0] v = '0;
    logic [NCH-1:0] w = '0;
    logic [AW-1:0]  a [NCH];
    logic [DW-1:0]  d [NCH];
    logic [BW-1:0]  b [NCH];

    logic [NCH-1:0]    req_valid, req_write;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH*BW-1:0] req_be;

    always_comb begin
        req_valid = v;
        req_write = w;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        for (int i = 0; i < NCH; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
            req_be[i*BW +: BW]    = b[i];
        end
    end

    logic [NCH-1:0] req_ready, resp_valid;
    logic [DW-1:0]  resp_data, sram_data_O;
    logic [DW-1:0]  sram_data_I = '0;
    logic [AW-1:0]  sram_address_out;
    logic [BW-1:0]  sram_we_bytes_out;
    logic sram_data_T, sram_we_out, sram_ce_out, sram_oe_out, sram_cen_out, sram_adv_ld_out, busy;

    logic [NCH-1:0] fp_req_ready, fp_resp_valid;
    logic [DW-1:0]  fp_resp_data, fp_sram_data_O;
    logic [DW-1:0]  fp_sram_data_I = '0;
    logic [AW-1:0]  fp_sram_address_out;
    logic [BW-1:0]  fp_sram_we_bytes_out;
    logic fp_sram_data_T, fp_sram_we_out, fp_sram_ce_out, fp_sram_oe_out, fp_sram_cen_out;
    logic fp_sram_adv_ld_out, fp_busy;

    zbt_sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .ARB_MODE(0)) u_dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .sram_address_out(sram_address_out), .sram_data_O(sram_data_O), .sram_data_I(sram_data_I),
        .sram_data_T(sram_data_T), .sram_we_bytes_out(sram_we_bytes_out), .sram_we_out(sram_we_out),
        .sram_ce_out(sram_ce_out), .sram_oe_out(sram_oe_out), .sram_cen_out(sram_cen_out),
        .sram_adv_ld_out(sram_adv_ld_out), .busy(busy)
    );

    zbt_sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .ARB_MODE(1)) u_dut_fp (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_ready(fp_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(fp_resp_valid), .resp_data(fp_resp_data),
        .sram_address_out(fp_sram_address_out), .sram_data_O(fp_sram_data_O), .sram_data_I(fp_sram_data_I),
        .sram_data_T(fp_sram_data_T), .sram_we_bytes_out(fp_sram_we_bytes_out), .sram_we_out(fp_sram_we_out),
        .sram_ce_out(fp_sram_ce_out), .sram_oe_out(fp_sram_oe_out), .sram_cen_out(fp_sram_cen_out),
        .sram_adv_ld_out(fp_sram_adv_ld_out), .busy(fp_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Unwritten SRAM locations read back as a known address-derived pattern.
    function automatic logic [31:0] init_val(input logic [17:0] ad);
        return (ad == 18'h00010) ? 32'hDEADBEEF : (32'hA5A50000 ^ 32'(ad));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic int low_idx(input logic [NCH-1:0] x);
        for (int i = 0; i < NCH; i++)
            if (x[i]) return i;
        return -1;
    endfunction

    logic [31:0] sram_mem [int];
    logic [31:0] ref_mem  [int];
    acc_t pinq[$];
    acc_t dq[$];
    rsp_t rspq[$];
    int   gnt_log[$];
    int   fp_log[$];

    int          cyc = 0;
    int          cnt = 0;
    int          hs_count = 0;
    logic        log_en = 1'b0;
    logic [2:0]  hist = '0;
    logic [17:0] last_addr = '0;
    logic [NCH-1:0] hs, exp_v;
    acc_t        e;
    rsp_t        r;
    int          ch_g;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            cnt = 0;
            hist = '0;
            last_addr = '0;
            pinq.delete();
            dq.delete();
            rspq.delete();
        end else begin
            if (cnt < 2) cnt++;
            check("rdy_onehot", $countones(req_ready) <= 1, 1);
            check("rdy_any", |req_ready, (cnt >= 2) && (|req_valid));
            check("rdy_not_valid", (req_ready & ~req_valid) != 0, 0);
            check("cen", sram_cen_out, cnt < 2);
            check("busy", busy, |hist);

            if (pinq.size() > 0 && pinq[0].due == cyc) begin
                e = pinq.pop_front();
                check("pins_acc",
                      {sram_ce_out, sram_we_out, sram_we_bytes_out, sram_adv_ld_out, sram_address_out},
                      {1'b0, ~e.wr, e.wr ? ~e.be : 4'hF, 1'b0, e.addr});
                last_addr = e.addr;
                e.due = cyc + 2;
                dq.push_back(e);
            end else begin
                check("pins_idle",
                      {sram_ce_out, sram_we_out, sram_we_bytes_out, sram_adv_ld_out, sram_address_out},
                      {1'b1, 1'b1, 4'hF, 1'b0, last_addr});
            end

            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                if (e.wr) begin
                    check("wr_data_cycle", {sram_data_T, sram_oe_out, sram_data_O}, {1'b0, 1'b1, e.wdata});
                    sram_mem[int'(e.addr)] = merge(sram_mem.exists(int'(e.addr)) ? sram_mem[int'(e.addr)]
                                                   : init_val(e.addr), sram_data_O, e.be);
                end else begin
                    check("rd_data_cycle", {sram_data_T, sram_oe_out}, 2'b10);
                    sram_data_I = sram_mem.exists(int'(e.addr)) ? sram_mem[int'(e.addr)] : init_val(e.addr);
                end
            end else begin
                check("bus_idle", {sram_data_T, sram_oe_out}, {1'b1, cnt < 2});
            end

            if (rspq.size() > 0 && rspq[0].due == cyc) begin
                r = rspq.pop_front();
                exp_v = '0;
                exp_v[r.ch] = 1'b1;
                check("resp_valid", resp_valid, exp_v);
                check("resp_data", resp_data, r.data);
            end else begin
                check("resp_idle", resp_valid, 0);
            end

            hs = req_valid & req_ready;
            hist = {hist[1:0], hs != 0};
            if (hs != 0) begin
                ch_g = low_idx(hs);
                hs_count++;
                e.due = cyc + 1;
                e.addr = a[ch_g];
                e.wr = w[ch_g];
                e.be = b[ch_g];
                e.wdata = d[ch_g];
                pinq.push_back(e);
                if (e.wr) begin
                    ref_mem[int'(e.addr)] = merge(ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)]
                                                  : init_val(e.addr), e.wdata, e.be);
                end else begin
                    r.due = cyc + 4;
                    r.ch = ch_g;
                    r.data = ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)] : init_val(e.addr);
                    rspq.push_back(r);
                end
            end
            if (log_en) begin
                gnt_log.push_back(low_idx(req_ready));
                fp_log.push_back(low_idx(fp_req_ready));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic wr, input logic [17:0] ad, input logic [31:0] dat,
                       input logic [3:0] be);
        v[ch] = 1'b1;
        w[ch] = wr;
        a[ch] = ad;
        d[ch] = dat;
        b[ch] = be;
    endtask

    int hs_before;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            a[i] = '0;
            d[i] = '0;
            b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {sram_address_out, sram_data_O, sram_data_T, sram_we_bytes_out, sram_we_out,
                           sram_ce_out, sram_oe_out, sram_cen_out, sram_adv_ld_out},
              {18'h0, 32'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        check("rst_resp", {resp_valid, resp_data, busy}, 37'h0);
        rst = 1'b0;

        // Contention: all channels valid from release; first cycle gets no grant.
        for (int i = 0; i < NCH; i++) put(i, 1'b0, 18'h00100 + 18'(i), 32'h0, 4'hF);
        step();
        log_en = 1'b1;
        repeat (8) step();
        v = '0;
        log_en = 1'b0;
        check("gnt_log_len", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
            check("rr_grant", gnt_log[i], i % 4);
            check("fp_grant", fp_log[i], 0);
        end
        repeat (6) step();

        // Single read.
        put(0, 1'b0, 18'h00010, 32'h0, 4'hF);
        step();
        v = '0;
        repeat (6) step();

        // Byte write at the top address, then read it and address 0.
        put(1, 1'b1, 18'h3FFFF, 32'h11223344, 4'b0101);
        step();
        put(1, 1'b0, 18'h3FFFF, 32'h0, 4'hF);
        step();
        put(1, 1'b0, 18'h00000, 32'h0, 4'hF);
        step();
        v = '0;
        repeat (6) step();

        // Back-to-back W/R/W/R on one channel.
        hs_before = hs_count;
        put(2, 1'b1, 18'h00050, 32'hCAFEF00D, 4'hF);
        step();
        put(2, 1'b0, 18'h00050, 32'h0, 4'hF);
        step();
        put(2, 1'b1, 18'h00051, 32'h0BADF00D, 4'b0011);
        step();
        put(2, 1'b0, 18'h00051, 32'h0, 4'hF);
        step();
        v = '0;
        repeat (6) step();
        check("b2b_handshakes", hs_count - hs_before, 4);

        // Reset with reads in flight and a write in its data cycle.
        put(3, 1'b0, 18'h00060, 32'h0, 4'hF);
        step();
        put(3, 1'b1, 18'h00061, 32'h5A5A5A5A, 4'hF);
        step();
        put(3, 1'b0, 18'h00062, 32'h0, 4'hF);
        step();
        put(3, 1'b0, 18'h00063, 32'h0, 4'hF);
        step();
        v = '0;
        #1;
        check("pre_rst_data_T", sram_data_T, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_pins", {sram_data_T, sram_ce_out, sram_cen_out, sram_oe_out}, 4'hF);
        check("async_rst_resp", {resp_valid, busy}, 5'h0);
        repeat (2) step();
        rst = 1'b0;
        put(0, 1'b0, 18'h00010, 32'h0, 4'hF);
        step();
        step();
        v = '0;
        repeat (8) step();
        check("drained", rspq.size() + pinq.size() + dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
